// File: rtl/seq_pkg.sv
// Shared definitions for the sequence generator / detector pair:
// FSM state encodings plus the default pattern and pattern length.
package seq_pkg;

    localparam logic [1:0] SEQ_ST_IDLE  = 2'd0;
    localparam logic [1:0] SEQ_ST_HUNT  = 2'd1;
    localparam logic [1:0] SEQ_ST_ALARM = 2'd2;

    typedef enum logic [1:0] {
        IDLE  = SEQ_ST_IDLE,
        HUNT  = SEQ_ST_HUNT,
        ALARM = SEQ_ST_ALARM
    } seq_state_e;

    // Default pattern, right-aligned; MSB of the used slice is the oldest bit.
    localparam int          SEQ_PAT_W   = 8;
    localparam logic [15:0] SEQ_PATTERN = 16'h00B8;

endpackage

// File: rtl/serial_sequence_detector_if.sv
// Signal bundle between the bit source / board and the sequence detector.
// Strobe protocol: bit_in is consumed in every cycle where bit_valid is high;
// there is no back-pressure, the detector always accepts. start is a 1-cycle
// pulse and takes priority over a bit strobed in the same cycle (that bit is lost).
interface serial_sequence_detector_if #(
    parameter int CNT_W = 8
);
    logic             start;
    logic             bit_valid;
    logic             bit_in;
    logic [7:0]       led;
    logic             match;
    logic [CNT_W-1:0] match_cnt;
    logic             buzzer;
    logic [1:0]       state_o;

    modport master (
        output start, bit_valid, bit_in,
        input  led, match, match_cnt, buzzer, state_o
    );

    modport slave (
        input  start, bit_valid, bit_in,
        output led, match, match_cnt, buzzer, state_o
    );
endinterface

// File: rtl/seq_shift_reg.sv
// PAT_W-bit history shift register with a saturating fill counter.
// full reports whether the fill count equals PAT_W after this cycle's shift,
// so the caller can qualify a comparison against the post-shift history.
// clr_fill drops the fill count while still shifting the data (used when
// overlapping detection is disabled, see SEQ_DET_OVERLAP_EN in the top).
module seq_shift_reg #(
    parameter int PAT_W = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             clr,
    input  logic             clr_fill,
    input  logic             shift,
    input  logic             bit_in,
    output logic [PAT_W-1:0] q,
    output logic             full
);
    localparam int                FILL_W   = $clog2(PAT_W + 1);
    localparam logic [FILL_W-1:0] FILL_MAX = FILL_W'(PAT_W);
    localparam logic [FILL_W-1:0] FILL_PRE = FILL_W'(PAT_W - 1);

    logic [FILL_W-1:0] fill_q;

    // History register and fill counter; clear beats shift.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            q      <= '0;
            fill_q <= '0;
        end else if (clr) begin
            q      <= '0;
            fill_q <= '0;
        end else begin
            if (shift) begin
                q <= {q[PAT_W-2:0], bit_in};
            end
            if (clr_fill) begin
                fill_q <= '0;
            end else if (shift && (fill_q != FILL_MAX)) begin
                fill_q <= fill_q + 1'b1;
            end
        end
    end

    // Fill level as it will be once this cycle's shift has been applied.
    always_comb begin
        full = (fill_q == FILL_MAX) || (shift && (fill_q == FILL_PRE));
    end

endmodule

// File: rtl/serial_sequence_detector.sv
// Serial pattern detector with alarm buzzer and match counter.
// Shifts in one bit per bit_valid strobe (MSB of PATTERN = oldest bit),
// pulses match one cycle after the completing bit, counts hits and holds
// buzzer for BUZZ_CYCLES cycles. Optional build macro:
//   SEQ_DET_OVERLAP_EN - keep the history after a match so overlapping
//                        occurrences are detected; otherwise a match needs
//                        PAT_W fresh bits.
module serial_sequence_detector
    import seq_pkg::*;
#(
    parameter int               PAT_W       = SEQ_PAT_W,
    parameter logic [PAT_W-1:0] PATTERN     = SEQ_PATTERN[PAT_W-1:0],
    parameter int               BUZZ_CYCLES = 100_000_000,
    parameter int               CNT_W       = 8
) (
    input  logic                        clk,
    input  logic                        rst,
    serial_sequence_detector_if.slave   bus
);
    localparam int                BUZZ_W    = (BUZZ_CYCLES > 1) ? $clog2(BUZZ_CYCLES) : 1;
    localparam logic [BUZZ_W-1:0] BUZZ_LOAD = BUZZ_W'(BUZZ_CYCLES - 1);

    seq_state_e        state_q, state_d;
    logic [PAT_W-1:0]  shreg;
    logic [PAT_W-1:0]  shreg_next;
    logic              fill_full;
    logic              active;
    logic              do_shift;
    logic              hit;
    logic              clr_fill;
    logic              match_q;
    logic              buzzer_q;
    logic [CNT_W-1:0]  cnt_q;
    logic [BUZZ_W-1:0] buzz_cnt_q;

    seq_shift_reg #(
        .PAT_W (PAT_W)
    ) u_shreg (
        .clk      (clk),
        .rst      (rst),
        .clr      (bus.start),
        .clr_fill (clr_fill),
        .shift    (do_shift),
        .bit_in   (bus.bit_in),
        .q        (shreg),
        .full     (fill_full)
    );

    // Shift qualification and same-cycle comparison against the post-shift history.
    always_comb begin
        active     = (state_q == HUNT) || (state_q == ALARM);
        do_shift   = bus.bit_valid && active && !bus.start;
        shreg_next = {shreg[PAT_W-2:0], bus.bit_in};
        hit        = do_shift && fill_full && (shreg_next == PATTERN);
`ifdef SEQ_DET_OVERLAP_EN
        clr_fill   = 1'b0;
`else
        clr_fill   = hit;
`endif
    end

    // Next-state logic; start restarts from any state, encoding 3 recovers to IDLE.
    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE: begin
                if (bus.start) state_d = HUNT;
            end
            HUNT: begin
                if (bus.start)  state_d = HUNT;
                else if (hit)   state_d = ALARM;
            end
            ALARM: begin
                if (bus.start)              state_d = HUNT;
                else if (hit)               state_d = ALARM;
                else if (buzz_cnt_q == '0)  state_d = HUNT;
            end
            default: state_d = IDLE;
        endcase
    end

    // State register, match pulse, buzzer, hold timer and saturating hit counter.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q    <= IDLE;
            match_q    <= 1'b0;
            buzzer_q   <= 1'b0;
            cnt_q      <= '0;
            buzz_cnt_q <= '0;
        end else begin
            state_q  <= state_d;
            match_q  <= hit;
            buzzer_q <= (state_d == ALARM);

            if (bus.start) begin
                cnt_q <= '0;
            end else if (hit && (cnt_q != '1)) begin
                cnt_q <= cnt_q + 1'b1;
            end

            if (bus.start) begin
                buzz_cnt_q <= '0;
            end else if (hit) begin
                buzz_cnt_q <= BUZZ_LOAD;
            end else if ((state_q == ALARM) && (buzz_cnt_q != '0)) begin
                buzz_cnt_q <= buzz_cnt_q - 1'b1;
            end
        end
    end

    // LED mirror of the history, newest bit in led[0].
    generate
        if (PAT_W >= 8) begin : g_led_wide
            always_comb bus.led = shreg[7:0];
        end else begin : g_led_narrow
            always_comb bus.led = {{(8 - PAT_W){1'b0}}, shreg};
        end
    endgenerate

    // Registered outputs onto the bus.
    always_comb begin
        bus.match     = match_q;
        bus.match_cnt = cnt_q;
        bus.buzzer    = buzzer_q;
        bus.state_o   = state_q;
    end

endmodule

// File: tb/tb_serial_sequence_detector.sv
// Directed bench for serial_sequence_detector: three instances
// (default 8-bit pattern, 4-bit pattern 1010, 2-bit match counter).
module tb_serial_sequence_detector;

    logic clk;
    logic rst;
    int   checks;
    int   failures;

    serial_sequence_detector_if #(.CNT_W(8)) if_a ();
    serial_sequence_detector_if #(.CNT_W(8)) if_b ();
    serial_sequence_detector_if #(.CNT_W(2)) if_c ();

    serial_sequence_detector #(
        .PAT_W(8), .PATTERN(8'hB8), .BUZZ_CYCLES(20), .CNT_W(8)
    ) dut_a (.clk(clk), .rst(rst), .bus(if_a));

    serial_sequence_detector #(
        .PAT_W(4), .PATTERN(4'b1010), .BUZZ_CYCLES(20), .CNT_W(8)
    ) dut_b (.clk(clk), .rst(rst), .bus(if_b));

    serial_sequence_detector #(
        .PAT_W(8), .PATTERN(8'hB8), .BUZZ_CYCLES(3), .CNT_W(2)
    ) dut_c (.clk(clk), .rst(rst), .bus(if_c));

    // Clock and reset
    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL timeout: bench did not complete");
        $fatal(1, "timeout");
    end

    // Checking
    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    // Driver tasks
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic pulse_start(input int which);
        case (which)
            0: if_a.start = 1'b1;
            1: if_b.start = 1'b1;
            default: if_c.start = 1'b1;
        endcase
        tick();
        if_a.start = 1'b0;
        if_b.start = 1'b0;
        if_c.start = 1'b0;
    endtask

    task automatic send_bit(input int which, input logic b);
        case (which)
            0: begin if_a.bit_valid = 1'b1; if_a.bit_in = b; end
            1: begin if_b.bit_valid = 1'b1; if_b.bit_in = b; end
            default: begin if_c.bit_valid = 1'b1; if_c.bit_in = b; end
        endcase
        tick();
        if_a.bit_valid = 1'b0;
        if_b.bit_valid = 1'b0;
        if_c.bit_valid = 1'b0;
    endtask

    initial begin
        logic [7:0] pat;
        logic [7:0] stream_b;
        logic [7:0] exp_b;
        int         exp_cnt_b;
        int         n_high;
        int         n_match;
        int         pulses;
        int         exp_c;

        checks   = 0;
        failures = 0;
        pat      = 8'hB8;
        stream_b = 8'b0101_0101;   // bit i (1-based) at index i-1: 1,0,1,0,1,0,1,0
`ifdef SEQ_DET_OVERLAP_EN
        exp_b     = 8'b1010_1000;  // matches after bits 4, 6, 8
        exp_cnt_b = 3;
`else
        exp_b     = 8'b1000_1000;  // matches after bits 4, 8
        exp_cnt_b = 2;
`endif
        rst = 1'b1;
        if_a.start = 1'b0; if_a.bit_valid = 1'b0; if_a.bit_in = 1'b0;
        if_b.start = 1'b0; if_b.bit_valid = 1'b0; if_b.bit_in = 1'b0;
        if_c.start = 1'b0; if_c.bit_valid = 1'b0; if_c.bit_in = 1'b0;
        tick();
        tick();

        // Reset state
        check("rst_state", if_a.state_o, 0);
        check("rst_led", if_a.led, 0);
        check("rst_match", if_a.match, 0);
        check("rst_cnt", if_a.match_cnt, 0);
        check("rst_buzzer", if_a.buzzer, 0);
        rst = 1'b0;
        tick();

        // 4-bit pattern 1010 over 10101010
        pulse_start(1);
        check("t2_state", if_b.state_o, 1);
        for (int i = 0; i < 8; i++) begin
            send_bit(1, stream_b[i]);
            check($sformatf("t2_match_bit%0d", i + 1), if_b.match, exp_b[i]);
        end
        check("t2_cnt", if_b.match_cnt, exp_cnt_b);
        check("t2_led", if_b.led, 8'h0A);

        // Saturating 2-bit counter over five back-to-back patterns
        pulse_start(2);
        pulses = 0;
        for (int r = 0; r < 5; r++) begin
            for (int i = 0; i < 8; i++) begin
                send_bit(2, pat[7 - i]);
                if (if_c.match === 1'b1) pulses++;
                if (i == 7) begin
                    exp_c = (r + 1 > 3) ? 3 : r + 1;
                    check($sformatf("t5_match_rep%0d", r), if_c.match, 1);
                    check($sformatf("t5_cnt_rep%0d", r), if_c.match_cnt, exp_c);
                end else begin
                    check("t5_no_match", if_c.match, 0);
                end
            end
        end
        tick();
        check("t5_pulses", pulses, 5);
        check("t5_cnt_final", if_c.match_cnt, 3);

        // Basic detection, buzzer duration, return to HUNT
        pulse_start(0);
        check("t1_state_hunt", if_a.state_o, 1);
        for (int i = 0; i < 8; i++) begin
            send_bit(0, pat[7 - i]);
            if (i < 7) check("t1_no_early_match", if_a.match, 0);
        end
        check("t1_match", if_a.match, 1);
        check("t1_led", if_a.led, 8'hB8);
        check("t1_cnt", if_a.match_cnt, 1);
        check("t1_state_alarm", if_a.state_o, 2);
        n_high  = 0;
        n_match = 0;
        while ((if_a.buzzer === 1'b1) && (n_high < 100)) begin
            n_high++;
            if (if_a.match === 1'b1) n_match++;
            tick();
        end
        check("t1_buzz_cycles", n_high, 20);
        check("t1_match_pulses", n_match, 1);
        check("t1_state_back", if_a.state_o, 1);
        check("t1_cnt_hold", if_a.match_cnt, 1);

        // Restart during HUNT with a simultaneous strobe
        for (int i = 0; i < 5; i++) send_bit(0, pat[7 - i]);
        check("t4_led_before", if_a.led, 8'h17);
        if_a.start = 1'b1;
        if_a.bit_valid = 1'b1;
        if_a.bit_in = 1'b1;
        tick();
        if_a.start = 1'b0;
        if_a.bit_valid = 1'b0;
        check("t4_led_clear", if_a.led, 0);
        check("t4_cnt_clear", if_a.match_cnt, 0);
        check("t4_state", if_a.state_o, 1);
        check("t4_match", if_a.match, 0);
        for (int i = 0; i < 8; i++) begin
            send_bit(0, pat[7 - i]);
            if (i < 7) check("t4_fresh_no_match", if_a.match, 0);
        end
        check("t4_fresh_match", if_a.match, 1);
        check("t4_fresh_cnt", if_a.match_cnt, 1);

        // Asynchronous reset in the middle of ALARM
        tick();
        check("t6_in_alarm", if_a.state_o, 2);
        #2;
        rst = 1'b1;
        #1;
        check("t6_buzzer", if_a.buzzer, 0);
        check("t6_state", if_a.state_o, 0);
        check("t6_cnt", if_a.match_cnt, 0);
        check("t6_led", if_a.led, 0);
        tick();
        rst = 1'b0;
        tick();

        // Strobes in IDLE are ignored
        for (int i = 0; i < 8; i++) begin
            send_bit(0, pat[7 - i]);
            check("t3_no_match", if_a.match, 0);
        end
        check("t3_led", if_a.led, 0);
        check("t3_state", if_a.state_o, 0);
        check("t3_cnt", if_a.match_cnt, 0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
